det_engine: RTL and testbench

DET_ENGINE -- requirements
Module: det_engine

---
 rtl/det_engine.sv | 201 ++++++++++++++++++++
 tb/tb_det_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/det_engine.sv
// det_engine: fraction-free (Bareiss) determinant of an NxN signed matrix.
// Defining DET_CYCLE_COUNT_EN adds a cycles[15:0] output counting busy cycles.
module det_engine #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int DW = 64
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Ack,
  input  logic [N*N*W-1:0]     input_arr_flat,
  output logic signed [DW-1:0] det,
  output logic                 q_I,
  output logic                 q_Load,
  output logic                 q_Pivot,
  output logic                 q_Comp,
  output logic                 q_Done
`ifdef DET_CYCLE_COUNT_EN
  ,
  output logic [15:0]          cycles
`endif
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [IW-1:0] PENULT = IW'(N - 2);
  localparam logic signed [DW-1:0] ONE = DW'(1);

  // One-hot encoding so each state flag is a register bit.
  typedef enum logic [4:0] {
    S_I     = 5'b00001,
    S_LOAD  = 5'b00010,
    S_PIVOT = 5'b00100,
    S_COMP  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t state_r, state_s;

  logic signed [DW-1:0] m_r [N][N];
  logic signed [W-1:0]  in_s [N][N];
  logic signed [DW-1:0] prev_r, det_r, comp_val_s;
  logic                 sign_neg_r;
  logic [IW-1:0]        k_r, r_r, i_r, j_r;

  logic load_s, swap_s, pivot_go_s, pivot_inc_s, zero_det_s, comp_s, comp_last_s;
  logic signed [2*DW-1:0] a_s, b_s, c_s, d_s, num_s, den_s;

  assign q_I     = state_r[0];
  assign q_Load  = state_r[1];
  assign q_Pivot = state_r[2];
  assign q_Comp  = state_r[3];
  assign q_Done  = state_r[4];
  assign det     = det_r;

  // Unpack the flat input bus; row 0 col 0 lives in the MSBs.
  always_comb begin
    for (int ra = 0; ra < N; ra++) begin
      for (int ca = 0; ca < N; ca++) begin
        in_s[ra][ca] = input_arr_flat[((N-1-ra)*N + (N-1-ca))*W +: W];
      end
    end
  end

  // Bareiss cross-product and exact division by the previous pivot at 2*DW.
  always_comb begin
    a_s = {{DW{m_r[i_r][j_r][DW-1]}}, m_r[i_r][j_r]};
    b_s = {{DW{m_r[k_r][k_r][DW-1]}}, m_r[k_r][k_r]};
    c_s = {{DW{m_r[i_r][k_r][DW-1]}}, m_r[i_r][k_r]};
    d_s = {{DW{m_r[k_r][j_r][DW-1]}}, m_r[k_r][j_r]};
    den_s = {{DW{prev_r[DW-1]}}, prev_r};
    num_s = a_s * b_s - c_s * d_s;
    comp_val_s = DW'(num_s / den_s);
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_r <= S_I;
    else       state_r <= state_s;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_s     = state_r;
    load_s      = 1'b0;
    swap_s      = 1'b0;
    pivot_go_s  = 1'b0;
    pivot_inc_s = 1'b0;
    zero_det_s  = 1'b0;
    comp_s      = 1'b0;
    comp_last_s = 1'b0;
    case (state_r)
      S_I: begin
        if (Start) state_s = S_LOAD;
        else       state_s = S_I;
      end
      S_LOAD: begin
        load_s  = 1'b1;
        state_s = S_PIVOT;
      end
      S_PIVOT: begin
        if (m_r[r_r][k_r] != '0) begin
          pivot_go_s = 1'b1;
          swap_s     = (r_r != k_r);
          state_s    = S_COMP;
        end else if (r_r == LAST) begin
          zero_det_s = 1'b1;
          state_s    = S_DONE;
        end else begin
          pivot_inc_s = 1'b1;
          state_s     = S_PIVOT;
        end
      end
      S_COMP: begin
        comp_s = 1'b1;
        if (i_r == LAST && j_r == LAST) begin
          comp_last_s = 1'b1;
          if (k_r == PENULT) state_s = S_DONE;
          else               state_s = S_PIVOT;
        end else begin
          state_s = S_COMP;
        end
      end
      S_DONE: begin
        if (Ack) state_s = S_I;
        else     state_s = S_DONE;
      end
      default: state_s = S_I;
    endcase
  end

  // Control registers: indices, previous pivot, sign and the result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      det_r      <= '0;
      prev_r     <= ONE;
      sign_neg_r <= 1'b0;
      k_r        <= '0;
      r_r        <= '0;
      i_r        <= '0;
      j_r        <= '0;
    end else if (load_s) begin
      prev_r     <= ONE;
      sign_neg_r <= 1'b0;
      k_r        <= '0;
      r_r        <= '0;
      i_r        <= '0;
      j_r        <= '0;
    end else if (pivot_inc_s) begin
      r_r <= r_r + IW'(1);
    end else if (pivot_go_s) begin
      if (swap_s) sign_neg_r <= ~sign_neg_r;
      i_r <= k_r + IW'(1);
      j_r <= k_r + IW'(1);
    end else if (zero_det_s) begin
      det_r <= '0;
    end else if (comp_s) begin
      if (comp_last_s) begin
        prev_r <= m_r[k_r][k_r];
        k_r    <= k_r + IW'(1);
        r_r    <= k_r + IW'(1);
        // The final element is written this cycle, so use the fresh value.
        if (k_r == PENULT) det_r <= sign_neg_r ? -comp_val_s : comp_val_s;
      end else if (j_r == LAST) begin
        i_r <= i_r + IW'(1);
        j_r <= k_r + IW'(1);
      end else begin
        j_r <= j_r + IW'(1);
      end
    end
  end

  // Working matrix: load, row swap, or one Bareiss element update.
  always_ff @(posedge Clk) begin
    if (load_s) begin
      for (int ra = 0; ra < N; ra++) begin
        for (int ca = 0; ca < N; ca++) begin
          m_r[ra][ca] <= {{(DW-W){in_s[ra][ca][W-1]}}, in_s[ra][ca]};
        end
      end
    end else if (swap_s) begin
      for (int ca = 0; ca < N; ca++) begin
        m_r[k_r][ca] <= m_r[r_r][ca];
        m_r[r_r][ca] <= m_r[k_r][ca];
      end
    end else if (comp_s) begin
      m_r[i_r][j_r] <= comp_val_s;
    end
  end

`ifdef DET_CYCLE_COUNT_EN
  // Busy-cycle counter; Load counts as the first cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                  cycles <= 16'd0;
    else if (load_s)                            cycles <= 16'd1;
    else if (state_r == S_PIVOT || state_r == S_COMP) cycles <= cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_det_engine.sv
// Directed bench for det_engine: three instances (N=8, N=3, N=2) share clock/reset/Ack.
module tb_det_engine;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic start_s = 1'b0;
  logic Ack = 1'b0;
  int   sel_s = 8;

  logic [511:0] in8_s = '0;
  logic [71:0]  in3_s = '0;
  logic [31:0]  in2_s = '0;
  logic signed [63:0] det8_s, det3_s, det2_s, detv_s;
  logic [4:0] q8_s, q3_s, q2_s, qv_s;  // {I, Load, Pivot, Comp, Done}
  logic start8_s, start3_s, start2_s;

  int mat_s [8][8];
  int n_cmp = 0;
  int n_bad = 0;
  int onehot_bad = 0;

  always #5 Clk = ~Clk;

  assign start8_s = start_s && (sel_s == 8);
  assign start3_s = start_s && (sel_s == 3);
  assign start2_s = start_s && (sel_s == 2);
  assign qv_s   = (sel_s == 8) ? q8_s   : (sel_s == 3) ? q3_s   : q2_s;
  assign detv_s = (sel_s == 8) ? det8_s : (sel_s == 3) ? det3_s : det2_s;

`ifdef DET_CYCLE_COUNT_EN
  logic [15:0] cyc8_s, cyc3_s, cyc2_s, cycv_s;
  assign cycv_s = (sel_s == 8) ? cyc8_s : (sel_s == 3) ? cyc3_s : cyc2_s;
`endif

  det_engine #(.N(8), .W(8), .DW(64)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .Start(start8_s), .Ack(Ack), .input_arr_flat(in8_s),
    .det(det8_s), .q_I(q8_s[4]), .q_Load(q8_s[3]), .q_Pivot(q8_s[2]),
    .q_Comp(q8_s[1]), .q_Done(q8_s[0])
`ifdef DET_CYCLE_COUNT_EN
    , .cycles(cyc8_s)
`endif
  );

  det_engine #(.N(3), .W(8), .DW(64)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .Start(start3_s), .Ack(Ack), .input_arr_flat(in3_s),
    .det(det3_s), .q_I(q3_s[4]), .q_Load(q3_s[3]), .q_Pivot(q3_s[2]),
    .q_Comp(q3_s[1]), .q_Done(q3_s[0])
`ifdef DET_CYCLE_COUNT_EN
    , .cycles(cyc3_s)
`endif
  );

  det_engine #(.N(2), .W(8), .DW(64)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Start(start2_s), .Ack(Ack), .input_arr_flat(in2_s),
    .det(det2_s), .q_I(q2_s[4]), .q_Load(q2_s[3]), .q_Pivot(q2_s[2]),
    .q_Comp(q2_s[1]), .q_Done(q2_s[0])
`ifdef DET_CYCLE_COUNT_EN
    , .cycles(cyc2_s)
`endif
  );

  // Exactly one state flag per instance in every sampled cycle.
  always @(negedge Clk) begin
    if ($countones(q8_s) != 1 || $countones(q3_s) != 1 || $countones(q2_s) != 1)
      onehot_bad++;
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pack_mat(input int n);
    logic [511:0] res;
    int v;
    res = '0;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        v = mat_s[r][c];
        res[((n-1-r)*n + (n-1-c))*8 +: 8] = v[7:0];
      end
    end
    return res;
  endfunction

  task automatic set_ident(input int sz);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        mat_s[r][c] = (r == c && r < sz) ? 1 : 0;
  endtask

  task automatic set_block8();
    set_ident(5);
    mat_s[5][5] = 7; mat_s[5][6] = 8; mat_s[5][7] = 2;
    mat_s[6][5] = 5; mat_s[6][6] = 2; mat_s[6][7] = 4;
    mat_s[7][5] = 1; mat_s[7][6] = 1; mat_s[7][7] = 9;
  endtask

  task automatic apply_mat(input int n);
    logic [511:0] p;
    p = pack_mat(n);
    in8_s = p;
    in3_s = p[71:0];
    in2_s = p[31:0];
    sel_s = n;
  endtask

  task automatic run_case(input int n, input longint exp_det, input int exp_cyc, input string tag);
    int cnt;
    apply_mat(n);
    @(negedge Clk); start_s = 1'b1;
    @(negedge Clk); start_s = 1'b0;
    check_val({tag, "_load"}, qv_s[3], 1);
    cnt = 0;
    while (qv_s[0] != 1'b1 && cnt < 2000) begin
      @(negedge Clk);
      cnt++;
    end
    check_val({tag, "_cyc"}, cnt, exp_cyc);
    check_val({tag, "_det"}, detv_s, exp_det);
`ifdef DET_CYCLE_COUNT_EN
    check_val({tag, "_cycles"}, cycv_s, exp_cyc);
`endif
  endtask

  task automatic release_done(input string tag);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    check_val({tag, "_ack_to_i"}, qv_s, 5'b10000);
  endtask

  initial begin
    int stable;
    int cnt;
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    check_val("rst_q8", q8_s, 5'b10000);
    check_val("rst_q3", q3_s, 5'b10000);
    check_val("rst_det8", det8_s, 0);
    check_val("rst_det2", det2_s, 0);

    set_ident(8);
    run_case(8, 1, 148, "id8");
    stable = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      start_s = (c == 5);
      if (q8_s == 5'b00001 && det8_s == 64'sd1) stable++;
    end
    check_val("id8_hold_stable", stable, 20);
    release_done("id8");
    check_val("id8_det_in_i", det8_s, 1);

    set_block8();
    run_case(8, -224, 148, "blk8");
    release_done("blk8");

    set_ident(0);
    mat_s[0][1] = 1; mat_s[1][0] = 1;
    run_case(2, -1, 4, "swp2");
    release_done("swp2");

    set_ident(0);
    mat_s[0][0] = 2;  mat_s[0][1] = -1; mat_s[0][2] = 0;
    mat_s[1][0] = -1; mat_s[1][1] = 2;  mat_s[1][2] = -1;
    mat_s[2][0] = 0;  mat_s[2][1] = -1; mat_s[2][2] = 2;
    run_case(3, 4, 8, "tri3");
    release_done("tri3");

    set_ident(0);
    mat_s[0][1] = 1; mat_s[0][2] = 2;
    mat_s[1][1] = 3; mat_s[1][2] = 4;
    mat_s[2][1] = 5; mat_s[2][2] = 6;
    run_case(3, 0, 4, "zer3");
    release_done("zer3");

    set_ident(8);
    apply_mat(8);
    @(negedge Clk); start_s = 1'b1;
    @(negedge Clk); start_s = 1'b0;
    cnt = 0;
    while (q8_s[1] != 1'b1 && cnt < 50) begin
      @(negedge Clk);
      cnt++;
    end
    check_val("mid_reach_comp", q8_s[1], 1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_val("mid_rst_q8", q8_s, 5'b10000);
    check_val("mid_rst_det8", det8_s, 0);
    @(negedge Clk);
    Reset = 1'b0;
    set_block8();
    run_case(8, -224, 148, "post");
    release_done("post");

    check_val("onehot_bad", onehot_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
